// File: rtl/frame_painter.sv
// frame_painter: VGA timing generator scanning a replicated frame buffer out as RGB332.
// Define FRAME_PAINTER_TESTPAT_EN to add the test_en colour-bar generator.
module frame_painter #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit SYNC_POL   = 1'b0,
    parameter int DIV_LOG2   = 1,
    parameter int FB_W       = 160,
    parameter int FB_H       = 120,
    parameter int SCALE_LOG2 = 2,
    parameter int ADDR_W     = 15
) (
    input  logic              clk50,
    input  logic              rst_n,
    input  logic [7:0]        frame_pixel,
    input  logic              buf_sel,
`ifdef FRAME_PAINTER_TESTPAT_EN
    input  logic              test_en,
`endif
    output logic [ADDR_W:0]   frame_addr,
    output logic              frame_rd,
    output logic [2:0]        vga_red,
    output logic [2:0]        vga_green,
    output logic [1:0]        vga_blue,
    output logic              vga_hsync,
    output logic              vga_vsync,
    output logic              frame_start
);
    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int DW    = DIV_LOG2 > 0 ? DIV_LOG2 : 1;

    logic [DW-1:0]     div;
    logic [HW-1:0]     h, h_nxt;
    logic [VW-1:0]     v, v_nxt;
    logic [ADDR_W-1:0] line_base;
    logic              pix_ce, sof, h_wrap, in_win, rd_en, buf_l, buf_cur;
    logic              hs_on, vs_on, hs_d, vs_d;
    logic [7:0]        pix_s1;

    assign pix_ce  = (DIV_LOG2 == 0) || (&div);
    assign sof     = (h == '0) && (v == '0);
    assign h_wrap  = 32'(h) == H_TOT - 1;
    assign h_nxt   = h_wrap ? '0 : h + HW'(1);
    assign v_nxt   = !h_wrap ? v : (32'(v) == V_TOT - 1) ? '0 : v + VW'(1);
    assign buf_cur = sof ? buf_sel : buf_l;
    assign in_win  = 32'(h) < H_ACTIVE && 32'(v) < V_ACTIVE &&
                     32'(h >> SCALE_LOG2) < FB_W && 32'(v >> SCALE_LOG2) < FB_H;
    assign hs_on   = 32'(h) >= H_ACTIVE + H_FP && 32'(h) < H_ACTIVE + H_FP + H_SYNC;
    assign vs_on   = 32'(v) >= V_ACTIVE + V_FP && 32'(v) < V_ACTIVE + V_FP + V_SYNC;

`ifdef FRAME_PAINTER_TESTPAT_EN
    localparam int BAR_W = H_ACTIVE / 8;
    localparam logic [7:0] BARS [8] = '{8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00};
    logic [HW-1:0] bx;
    logic [2:0]    bar, bar_d;
    logic          act_d;

    assign rd_en  = in_win && !test_en;
    assign pix_s1 = test_en ? (act_d ? BARS[bar_d] : 8'h00) : (frame_rd ? frame_pixel : 8'h00);

    // bar tracks which eighth of the line h sits in, avoiding a divider
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            bx    <= '0;
            bar   <= '0;
            bar_d <= '0;
            act_d <= 1'b0;
        end else if (pix_ce) begin
            bar_d <= bar;
            act_d <= 32'(h) < H_ACTIVE && 32'(v) < V_ACTIVE;
            if (h_wrap) begin
                bx  <= '0;
                bar <= '0;
            end else if (32'(bx) == BAR_W - 1) begin
                bx  <= '0;
                bar <= bar + 3'd1;
            end else begin
                bx  <= bx + HW'(1);
            end
        end
    end
`else
    assign rd_en  = in_win;
    assign pix_s1 = frame_rd ? frame_pixel : 8'h00;
`endif

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            div         <= '0;
            h           <= '0;
            v           <= '0;
            line_base   <= '0;
            buf_l       <= 1'b0;
            frame_addr  <= '0;
            frame_rd    <= 1'b0;
            hs_d        <= 1'b0;
            vs_d        <= 1'b0;
            vga_red     <= '0;
            vga_green   <= '0;
            vga_blue    <= '0;
            vga_hsync   <= ~SYNC_POL;
            vga_vsync   <= ~SYNC_POL;
            frame_start <= 1'b0;
        end else begin
            div         <= div + DW'(1);
            frame_start <= pix_ce && sof;
            if (pix_ce) begin
                h <= h_nxt;
                v <= v_nxt;
                if (sof)
                    buf_l <= buf_sel;
                // line_base steps by one buffer row each time v crosses a replication boundary
                if (h_wrap)
                    line_base <= (v_nxt == '0) ? '0 :
                                 ((v_nxt >> SCALE_LOG2) != (v >> SCALE_LOG2)) ? line_base + ADDR_W'(FB_W) : line_base;
                frame_rd <= rd_en;
                if (rd_en)
                    frame_addr <= {buf_cur, line_base + ADDR_W'(h >> SCALE_LOG2)};
                hs_d <= hs_on;
                vs_d <= vs_on;
                {vga_red, vga_green, vga_blue} <= pix_s1;
                vga_hsync <= hs_d ? SYNC_POL : ~SYNC_POL;
                vga_vsync <= vs_d ? SYNC_POL : ~SYNC_POL;
            end
        end
    end
endmodule

// File: tb/tb_frame_painter.sv
// tb_frame_painter: random-pixel scan-out of a small cropped/windowed mode against a pixel-index model.
module tb_frame_painter;
    localparam int HA = 32, HFP = 4, HS = 6, HBP = 6;
    localparam int VA = 16, VFP = 2, VS = 2, VBP = 4;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FT = HT * VT;
    localparam int FBW = 10, FBH = 3, SC = 2, AW = 6;
    localparam bit POL = 1'b0;

    logic          clk50 = 1'b0;
    logic          rst_n;
    logic [7:0]    frame_pixel;
    logic          buf_sel;
    logic [AW:0]   frame_addr;
    logic          frame_rd;
    logic [2:0]    vga_red, vga_green;
    logic [1:0]    vga_blue;
    logic          vga_hsync, vga_vsync, frame_start;

    int n_chk = 0, n_fail = 0;
    int e, k0, k1;
    int m_addr, m_rd, m_rgb, m_hs, m_vs, m_fs, m_buf;

    frame_painter #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_POL(POL), .DIV_LOG2(1), .FB_W(FBW), .FB_H(FBH),
        .SCALE_LOG2(SC), .ADDR_W(AW)
    ) dut (
        .clk50(clk50), .rst_n(rst_n), .frame_pixel(frame_pixel), .buf_sel(buf_sel),
`ifdef FRAME_PAINTER_TESTPAT_EN
        .test_en(1'b0),
`endif
        .frame_addr(frame_addr), .frame_rd(frame_rd),
        .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .frame_start(frame_start)
    );

    always #10 clk50 = ~clk50;

    function automatic int px_h(int k); return k % HT; endfunction
    function automatic int px_v(int k); return (k / HT) % VT; endfunction
    function automatic bit inw(int k);
        return px_h(k) < HA && px_v(k) < VA && px_h(k) / (1 << SC) < FBW && px_v(k) / (1 << SC) < FBH;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s e=%0d: observed %0d expected %0d", tag, e, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("frame_addr", 32'(frame_addr), m_addr);
        chk("frame_rd", 32'(frame_rd), m_rd);
        chk("rgb", 32'({vga_red, vga_green, vga_blue}), m_rgb);
        chk("hsync", 32'(vga_hsync), m_hs);
        chk("vsync", 32'(vga_vsync), m_vs);
        chk("frame_start", 32'(frame_start), m_fs);
    endtask

    task automatic model_reset();
        e = 0; k0 = -1;
        m_addr = 0; m_rd = 0; m_rgb = 0; m_fs = 0; m_buf = 0;
        m_hs = 32'(!POL); m_vs = 32'(!POL);
    endtask

    // one clk50 cycle: pixel k0 = e/2-1 is issued on every second edge after reset release
    task automatic step();
        @(posedge clk50);
        e++;
        m_fs = 0;
        if (e % 2 == 0) begin
            k0 = e / 2 - 1;
            k1 = k0 - 1;
            if (k0 % FT == 0) begin
                m_buf = 32'(buf_sel);
                m_fs = 1;
            end
            m_rgb = (k1 >= 0 && inw(k1)) ? 32'(frame_pixel) : 0;
            m_hs = (k1 >= 0 && px_h(k1) >= HA + HFP && px_h(k1) < HA + HFP + HS) ? 32'(POL) : 32'(!POL);
            m_vs = (k1 >= 0 && px_v(k1) >= VA + VFP && px_v(k1) < VA + VFP + VS) ? 32'(POL) : 32'(!POL);
            m_rd = 32'(inw(k0));
            if (inw(k0))
                m_addr = m_buf * (1 << AW) + (px_v(k0) >> SC) * FBW + (px_h(k0) >> SC);
        end
        @(negedge clk50);
        check_all();
        frame_pixel = 8'($urandom);
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst_n = 1'b0;
        buf_sel = 1'b0;
        frame_pixel = 8'hE3;
        model_reset();
        repeat (3) @(negedge clk50);
        check_all();
        rst_n = 1'b1;
        run(2 * 2 * FT + 20);
        buf_sel = 1'b1;
        run(FT);
        buf_sel = 1'b0;
        run(2 * FT);
        buf_sel = 1'b1;
        run(2 * FT);
        for (int i = 0; i < 4 * FT && !(e % 2 == 0 && px_h(k0) == 20 && px_v(k0) == 5); i++) step();
        chk("reached_reset_point", 32'(px_h(k0) == 20 && px_v(k0) == 5), 1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (2) @(negedge clk50);
        check_all();
        buf_sel = 1'b0;
        rst_n = 1'b1;
        run(2 * FT + 200);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
